// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes and the request legality check.
package riscv_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A request is rejected when misaligned for its size, when funct3 is not
    // a load/store width, or when a store asks for an unsigned width.
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = off[0];
            F3_W:        err = (off != 2'b00);
            default:     err = 1'b1;
        endcase
        if (we && funct3[2]) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Bundle of the execute-stage request/response handshake and the dmem port.
// master: the execute stage plus the data memory; slave: the load/store unit.
interface riscv_lsu_if #(
    parameter int AW = 7
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Lane steering for a word-wide memory: extracts and extends load data, and
// builds the read-modify-write word for byte/halfword stores.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, extend it for loads, and splice store data in.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        byte_sel = word_i[7:0];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = 32'h0;
        merge_o  = word_i;

        case (off_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
        endcase

        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = 32'h0;
        endcase

        case (funct3_i)
            F3_B: begin
                case (off_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, sub-word stores done as a
// read-modify-write on a memory without byte enables.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic      clk,
    input  logic      rst,
    riscv_lsu_if.slave bus
);
    lsu_state_e    state_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   load_data;
    logic [31:0]   merge_data;

    riscv_lsu_align u_align (
        .word_i   (bus.mem_rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Control FSM with request latches and registered handshake/strobe outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        off_q       <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= bus.req_addr[AW+1:2];
                            // Full-word stores skip the read; everything else reads first.
                            if (bus.req_we && bus.req_funct3 == F3_W) begin
                                state_q  <= ST_WR;
                                mem_we_q <= 1'b1;
                            end else begin
                                state_q <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        state_q  <= ST_MERGE;
                        mem_we_q <= 1'b1;
                    end else begin
                        state_q      <= ST_RESP;
                        mem_en_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_MERGE, ST_WR: begin
                    state_q      <= ST_RESP;
                    mem_en_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_en_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Data paths follow mem_rdata in the same cycle, so they stay combinational.
    always_comb begin
        bus.mem_wdata  = 32'h0;
        bus.resp_rdata = 32'h0;
        case (state_q)
            ST_MERGE: bus.mem_wdata = merge_data;
            ST_WR:    bus.mem_wdata = wdata_q;
            ST_RESP:  if (!we_q && !resp_err_q) bus.resp_rdata = load_data;
            default:  ;
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the core's data path. It accepts one load or store request at a time from the execute stage and drives the `riscv_dmem_syncram` port (`en`, `we`, `addr`, `wdata`, `rdata`). It implements RV32I byte, halfword and word accesses on a word-wide memory without byte enables:
- sub-word stores use a read-modify-write sequence;
- loads are sign- or zero-extended.

The unit sits between the execute stage and the data memory. It stalls the pipeline through `req_ready`.

## Interface
- `AW`, default 7: data-memory word-address width; must match the dmem instance.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  misaligned or illegal request; qualified by `resp_valid`
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `mem_en`  out  1  dmem enable
- `mem_we`  out  1  dmem write enable
- `mem_addr`  out  AW  dmem word address
- `mem_wdata`  out  32  dmem write data
- `mem_rdata`  in  32  dmem read data, valid the cycle after a read is sampled

## Operation
- States: IDLE, RD, MERGE, WR, RESP.
- In IDLE, `req_ready`=1. All other outputs are decoded from the state and the latched request.
- **Accept.** A request is accepted on `req_valid & req_ready`. The unit latches `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- **Error check.** A request is an error if any of these holds:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1.
- **Transitions on accept:**
  - error → RESP, with no memory access;
  - load → RD;
  - SW → WR;
  - SB or SH → RD.
- **RD state:** `mem_en`=1, `mem_we`=0, `mem_addr`=`addr[AW+1:2]`. Next state is RESP for a load, MERGE for a store.
- **MERGE state:** `mem_en`=1, `mem_we`=1. `mem_wdata` is `mem_rdata` with the addressed byte or halfword lane replaced by `req_wdata[7:0]` or `[15:0]`. Next state is RESP.
- **WR state:** `mem_en`=1, `mem_we`=1, `mem_wdata`=`req_wdata`. Next state is RESP.
- **RESP state:** `resp_valid`=1 for one cycle, then IDLE.
  - For a load, `resp_rdata` is the lane selected by `addr[1:0]` from `mem_rdata`. It is sign-extended for B and H, zero-extended for BU and HU.
- **Address width.** `req_addr` bits above AW+1 are ignored, so addresses wrap modulo 2^(AW+2) bytes.
- **Outputs outside their active states:**
  - `mem_*` are 0;
  - `resp_*` are 0.
- **No response backpressure.** The consumer must take `resp_valid` in its cycle.

## Timing
Latency is counted from the accept cycle T.
- Error: `resp_valid` at T+1.
- Load: memory read sampled at the end of T+1; `resp_valid` at T+2.
- SW: write sampled at the end of T+1; `resp_valid` at T+2.
- SB/SH: read at T+1, write at T+2; `resp_valid` at T+3.
- `req_ready`=0 from T+1 through the RESP cycle. The next accept is possible one cycle after RESP.
- **Reset values:** `req_ready`=1; every other output is 0.
- **Reset mid-operation:** state returns to IDLE on the edge where `rst`=1, and the latched request is discarded.
  - A dmem write presented in the same cycle as `rst`=1 is still sampled by the memory. Reset does not suppress a write already on the bus.
  - Reset in RD leaves memory unchanged.
- While `rst`=1, `req_valid` is ignored.

## Structure
- Package `riscv_lsu_pkg` holds:
  - state encodings (IDLE=0, RD=1, MERGE=2, WR=3, RESP=4, 3-bit);
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `riscv_lsu_align` is purely combinational. It takes word, `addr[1:0]`, funct3 and store data, and produces the extended load data and the merged store word.
- The FSM and request latches live in the top level.

## Test plan
Use AW=7 with a behavioural `riscv_dmem_syncram` attached.
1. SW addr 0x0C data 0xDEADBEEF, then LW 0x0C → `resp_valid` at accept+2 with `resp_rdata`=0xDEADBEEF; `req_ready` low for 2 cycles.
2. SB 0x0D data 0x000000AA → response at accept+3 and mem[3]=0xDEADAAEF. Then LBU 0x0D → 0x000000AA, and LB 0x0D → 0xFFFFFFAA.
3. SH 0x0E data 0x1234 → mem[3]=0x1234AAEF. Then LH 0x0E → 0x00001234, LHU 0x0C → 0x0000AAEF, and LH 0x0C → 0xFFFFAAEF.
4. Errors with no memory access:
   - LW 0x0D → `resp_err`=1 at accept+1, `mem_en` never high;
   - SH 0x0F → `resp_err`=1, mem[3] unchanged;
   - funct3 011 → `resp_err`=1.
5. Wrap: SW 0x200 data 0x11111111, then LW 0x000 → 0x11111111.
6. Reset during the RD cycle of SB 0x0C data 0x55 → the next cycle has all outputs 0 and `req_ready`=1; a following LW 0x0C returns the prior mem[3] unchanged.
